// File: rtl/mips_pkg.sv
// mips_pkg: shared constants and encodings for the MIPS pipeline control blocks.
`default_nettype none

package mips_pkg;

   localparam logic [4:0] REG_ZERO   = 5'd0;

   localparam logic [1:0] MEM_IDLE   = 2'd0;
   localparam logic [1:0] MEM_WAIT   = 2'd1;
   localparam logic [1:0] MEM_DONE   = 2'd2;

   localparam int         EXE_CMD_W  = 4;
   localparam int         REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      ST_IDLE = MEM_IDLE,
      ST_WAIT = MEM_WAIT,
      ST_DONE = MEM_DONE
   } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// hazard_detect: combinational RAW hazard detection between ID and the EXE/MEM stages.
`default_nettype none

module hazard_detect
   import mips_pkg::*;
#(
   parameter int FWD_EN = 1
) (
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_r_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   output logic                  raw_hz
);

   logic match_x;
   logic match_m;

   // r0 is hard-wired zero, so a write to it can never create a dependency
   assign match_x = exe_wb_en && (exe_dest != REG_ZERO) &&
                    ((exe_dest == id_src1) || (id_two_src && (exe_dest == id_src2)));
   assign match_m = mem_wb_en && (mem_dest != REG_ZERO) &&
                    ((mem_dest == id_src1) || (id_two_src && (mem_dest == id_src2)));

   // With forwarding only a load in EXE cannot be bypassed in time
   assign raw_hz = (FWD_EN != 0) ? (match_x && exe_mem_r_en) : (match_x || match_m);

endmodule

`default_nettype wire

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline freeze/flush/bubble sequencer with SRAM wait FSM.
// Optional performance counters enabled by defining HAZARD_CTRL_PERF_EN.
`default_nettype none

module hazard_ctrl
   import mips_pkg::*;
#(
   parameter int FWD_EN      = 1,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [REG_ADDR_W-1:0] id_src1,
   input  logic [REG_ADDR_W-1:0] id_src2,
   input  logic                  id_two_src,
   input  logic [REG_ADDR_W-1:0] exe_dest,
   input  logic                  exe_wb_en,
   input  logic                  exe_mem_r_en,
   input  logic [REG_ADDR_W-1:0] mem_dest,
   input  logic                  mem_wb_en,
   input  logic                  exe_br_taken,
   input  logic                  mem_req,
   input  logic                  sram_ready,
   output logic                  pc_freeze,
   output logic                  if_id_freeze,
   output logic                  if_id_flush,
   output logic                  id_ex_bubble,
   output logic                  id_ex_freeze,
   output logic                  ex_mem_freeze,
   output logic                  mem_wb_freeze,
   output logic                  mem_timeout_err
`ifdef HAZARD_CTRL_PERF_EN
   ,
   output logic [31:0]           raw_stall_cnt,
   output logic [31:0]           br_flush_cnt,
   output logic [31:0]           mem_stall_cnt
`endif
);

   localparam int               CNT_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CNT_W-1:0] TMO   = CNT_W'(MEM_TIMEOUT);

   mem_state_t       state;
   logic [CNT_W-1:0] wait_cnt;
   logic [CNT_W-1:0] wait_cnt_nxt;
   logic             raw_hz;
   logic             mem_stall;
   logic             br_act;
   logic             raw_act;

   hazard_detect #(
      .FWD_EN (FWD_EN)
   ) u_detect (
      .id_src1      (id_src1),
      .id_src2      (id_src2),
      .id_two_src   (id_two_src),
      .exe_dest     (exe_dest),
      .exe_wb_en    (exe_wb_en),
      .exe_mem_r_en (exe_mem_r_en),
      .mem_dest     (mem_dest),
      .mem_wb_en    (mem_wb_en),
      .raw_hz       (raw_hz)
   );

   assign wait_cnt_nxt = (wait_cnt == TMO) ? wait_cnt : wait_cnt + 1'b1;

   // DONE deliberately ignores mem_req so the request just served is not re-issued
   assign mem_stall = ((state == ST_IDLE) && mem_req && !sram_ready) || (state == ST_WAIT);
   assign br_act    = !mem_stall && exe_br_taken;
   assign raw_act   = !mem_stall && !exe_br_taken && raw_hz;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         mem_timeout_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mem_req) begin
                  if (sram_ready) begin
                     state <= ST_DONE;
                  end else begin
                     state    <= ST_WAIT;
                     wait_cnt <= '0;
                  end
               end
            end
            ST_WAIT: begin
               if (sram_ready) begin
                  state <= ST_DONE;
               end else begin
                  wait_cnt <= wait_cnt_nxt;
                  // Error is only reported; the pipeline keeps waiting for the SRAM
                  if (wait_cnt_nxt == TMO) begin
                     mem_timeout_err <= 1'b1;
                  end
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      pc_freeze     = 1'b0;
      if_id_freeze  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_bubble  = 1'b0;
      id_ex_freeze  = 1'b0;
      ex_mem_freeze = 1'b0;
      mem_wb_freeze = 1'b0;
      if (!rst) begin
         if (mem_stall) begin
            pc_freeze     = 1'b1;
            if_id_freeze  = 1'b1;
            id_ex_freeze  = 1'b1;
            ex_mem_freeze = 1'b1;
            mem_wb_freeze = 1'b1;
         end else if (exe_br_taken) begin
            // ID holds a wrong-path instruction, so any hazard it shows is moot
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
         end else if (raw_hz) begin
            pc_freeze    = 1'b1;
            if_id_freeze = 1'b1;
            id_ex_bubble = 1'b1;
         end
      end
   end

`ifdef HAZARD_CTRL_PERF_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         raw_stall_cnt <= '0;
         br_flush_cnt  <= '0;
         mem_stall_cnt <= '0;
      end else begin
         if (raw_act)   raw_stall_cnt <= raw_stall_cnt + 32'd1;
         if (br_act)    br_flush_cnt  <= br_flush_cnt + 32'd1;
         if (mem_stall) mem_stall_cnt <= mem_stall_cnt + 32'd1;
      end
   end
`else
   logic unused_act;
   assign unused_act = br_act ^ raw_act;
`endif

endmodule

`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks of hazard_ctrl, FWD_EN=1 and FWD_EN=0 side by side.
`default_nettype none

module tb_hazard_ctrl;

   localparam logic [6:0] NONE = 7'b0000000;
   localparam logic [6:0] MEMS = 7'b1100111;
   localparam logic [6:0] BRF  = 7'b0011000;
   localparam logic [6:0] RAW  = 7'b1101000;

   typedef struct packed {
      logic [4:0] s1;
      logic [4:0] s2;
      logic       two;
      logic [4:0] xd;
      logic       xw;
      logic       xl;
      logic [4:0] md;
      logic       mw;
      logic       br;
      logic       req;
      logic       rdy;
   } vec_t;

   typedef struct packed {
      vec_t       in;
      logic [6:0] e1;
      logic [6:0] e0;
   } tv_t;

   typedef struct packed {
      logic [6:0] e1;
      logic [6:0] e0;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   vec_t       cur;
   logic [6:0] o1, o0;
   logic       err1, err0;
   int         checks = 0;
   int         errors = 0;
   exp_t       sb[$];
   tv_t        tbl[12];
   int         m_raw1 = 0, m_raw0 = 0, m_br = 0, m_mem = 0;

   logic pf1, iff1, ifl1, bub1, idf1, exf1, mwf1;
   logic pf0, iff0, ifl0, bub0, idf0, exf0, mwf0;
`ifdef HAZARD_CTRL_PERF_EN
   logic [31:0] rc1, bc1, mc1, rc0, bc0, mc0;
`endif

   always #5 clk = ~clk;

   hazard_ctrl #(.FWD_EN(1), .MEM_TIMEOUT(15)) dut (
      .clk(clk), .rst(rst),
      .id_src1(cur.s1), .id_src2(cur.s2), .id_two_src(cur.two),
      .exe_dest(cur.xd), .exe_wb_en(cur.xw), .exe_mem_r_en(cur.xl),
      .mem_dest(cur.md), .mem_wb_en(cur.mw), .exe_br_taken(cur.br),
      .mem_req(cur.req), .sram_ready(cur.rdy),
      .pc_freeze(pf1), .if_id_freeze(iff1), .if_id_flush(ifl1), .id_ex_bubble(bub1),
      .id_ex_freeze(idf1), .ex_mem_freeze(exf1), .mem_wb_freeze(mwf1),
      .mem_timeout_err(err1)
`ifdef HAZARD_CTRL_PERF_EN
      , .raw_stall_cnt(rc1), .br_flush_cnt(bc1), .mem_stall_cnt(mc1)
`endif
   );

   hazard_ctrl #(.FWD_EN(0), .MEM_TIMEOUT(15)) dut0 (
      .clk(clk), .rst(rst),
      .id_src1(cur.s1), .id_src2(cur.s2), .id_two_src(cur.two),
      .exe_dest(cur.xd), .exe_wb_en(cur.xw), .exe_mem_r_en(cur.xl),
      .mem_dest(cur.md), .mem_wb_en(cur.mw), .exe_br_taken(cur.br),
      .mem_req(cur.req), .sram_ready(cur.rdy),
      .pc_freeze(pf0), .if_id_freeze(iff0), .if_id_flush(ifl0), .id_ex_bubble(bub0),
      .id_ex_freeze(idf0), .ex_mem_freeze(exf0), .mem_wb_freeze(mwf0),
      .mem_timeout_err(err0)
`ifdef HAZARD_CTRL_PERF_EN
      , .raw_stall_cnt(rc0), .br_flush_cnt(bc0), .mem_stall_cnt(mc0)
`endif
   );

   assign o1 = {pf1, iff1, ifl1, bub1, idf1, exf1, mwf1};
   assign o0 = {pf0, iff0, ifl0, bub0, idf0, exf0, mwf0};

   function automatic vec_t mv(input logic [4:0] s1, input logic [4:0] s2, input logic two,
                               input logic [4:0] xd, input logic xw, input logic xl,
                               input logic [4:0] md, input logic mw, input logic br,
                               input logic req, input logic rdy);
      vec_t v;
      v = '{s1:s1, s2:s2, two:two, xd:xd, xw:xw, xl:xl, md:md, mw:mw, br:br, req:req, rdy:rdy};
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void tally(input logic [6:0] e, input bit fwd1);
      if (fwd1) begin
         if (e == MEMS) m_mem++;
         if (e == BRF)  m_br++;
         if (e == RAW)  m_raw1++;
      end else if (e == RAW) begin
         m_raw0++;
      end
   endfunction

   // Drive one cycle of stimulus, queue the expectation, compare at the falling edge
   task automatic step(input string name, input vec_t v, input logic [6:0] e1, input logic [6:0] e0);
      exp_t e;
      cur = v;
      sb.push_back('{e1:e1, e0:e0});
      tally(e1, 1'b1);
      tally(e0, 1'b0);
      @(negedge clk);
      e = sb.pop_front();
      check({name, " fwd1"}, {25'd0, o1}, {25'd0, e.e1});
      check({name, " fwd0"}, {25'd0, o0}, {25'd0, e.e0});
      @(posedge clk);
      #1;
   endtask

   task automatic clear_model();
      m_raw1 = 0; m_raw0 = 0; m_br = 0; m_mem = 0;
   endtask

   initial begin
      tbl[0]  = '{in:mv(0,0,0, 0,0,0, 0,0,0,0,0), e1:NONE, e0:NONE};
      tbl[1]  = '{in:mv(5,0,0, 5,1,1, 0,0,0,0,0), e1:RAW,  e0:RAW };
      tbl[2]  = '{in:mv(5,0,0, 0,0,0, 0,0,0,0,0), e1:NONE, e0:NONE};
      tbl[3]  = '{in:mv(5,0,0, 5,1,0, 0,0,0,0,0), e1:NONE, e0:RAW };
      tbl[4]  = '{in:mv(3,7,1, 0,0,0, 7,1,0,0,0), e1:NONE, e0:RAW };
      tbl[5]  = '{in:mv(3,7,0, 0,0,0, 7,1,0,0,0), e1:NONE, e0:NONE};
      tbl[6]  = '{in:mv(3,0,1, 0,0,0, 0,1,0,0,0), e1:NONE, e0:NONE};
      tbl[7]  = '{in:mv(5,0,0, 5,1,1, 0,0,1,0,0), e1:BRF,  e0:BRF };
      tbl[8]  = '{in:mv(1,2,1, 9,1,0, 0,0,1,0,0), e1:BRF,  e0:BRF };
      tbl[9]  = '{in:mv(5,0,0, 5,0,1, 0,0,0,0,0), e1:NONE, e0:NONE};
      tbl[10] = '{in:mv(0,0,0, 0,1,1, 0,0,0,0,0), e1:NONE, e0:NONE};
      tbl[11] = '{in:mv(1,6,1, 6,1,1, 6,1,0,0,0), e1:RAW,  e0:RAW };

      // Reset holds every output low even with a hazard presented
      rst = 1'b1;
      cur = mv(5,0,0, 5,1,1, 0,0,0,1,0);
      #2;
      check("reset outputs fwd1", {25'd0, o1}, 32'd0);
      check("reset outputs fwd0", {25'd0, o0}, 32'd0);
      check("reset err", {30'd0, err1, err0}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();

      foreach (tbl[i]) step($sformatf("vec%0d", i), tbl[i].in, tbl[i].e1, tbl[i].e0);

      // SRAM answers in the 4th stall cycle while a taken branch waits in EXE
      for (int i = 0; i < 4; i++)
         step($sformatf("sram wait%0d", i), mv(0,0,0, 0,0,0, 0,0,1,1,(i == 3)), MEMS, MEMS);
      step("sram done br", mv(0,0,0, 0,0,0, 0,0,1,1,0), BRF, BRF);
      step("sram idle", mv(0,0,0, 0,0,0, 0,0,0,0,0), NONE, NONE);

      // Immediate ready: no stall, and DONE does not re-issue the held request
      step("sram fast", mv(0,0,0, 0,0,0, 0,0,0,1,1), NONE, NONE);
      step("sram fast done", mv(0,0,0, 0,0,0, 0,0,0,1,0), NONE, NONE);
      step("sram fast idle", mv(0,0,0, 0,0,0, 0,0,0,0,0), NONE, NONE);

      // Load-use costs one bubble: hazard then the load moves on
      step("lu stall", mv(4,0,0, 4,1,1, 0,0,0,0,0), RAW, RAW);
      step("lu clear", mv(4,0,0, 0,0,0, 4,1,0,0,0), NONE, RAW);

`ifdef HAZARD_CTRL_PERF_EN
      check("raw_cnt fwd1", rc1, 32'(m_raw1));
      check("br_cnt fwd1",  bc1, 32'(m_br));
      check("mem_cnt fwd1", mc1, 32'(m_mem));
      check("raw_cnt fwd0", rc0, 32'(m_raw0));
      check("br_cnt fwd0",  bc0, 32'(m_br));
      check("mem_cnt fwd0", mc0, 32'(m_mem));
`endif

      check("err before timeout", {30'd0, err1, err0}, 32'd0);

      // SRAM never answers: stall persists, error rises and sticks
      for (int i = 0; i < 5; i++)
         step($sformatf("tmo%0d", i), mv(0,0,0, 0,0,0, 0,0,0,1,0), MEMS, MEMS);
      check("err early", {30'd0, err1, err0}, 32'd0);
      for (int i = 5; i < 20; i++)
         step($sformatf("tmo%0d", i), mv(0,0,0, 0,0,0, 0,0,0,1,0), MEMS, MEMS);
      check("err raised", {30'd0, err1, err0}, 32'd3);
      for (int i = 20; i < 23; i++)
         step($sformatf("tmo%0d", i), mv(0,0,0, 0,0,0, 0,0,1,1,0), MEMS, MEMS);
      check("err sticky", {30'd0, err1, err0}, 32'd3);

      // Asynchronous reset in WAIT: outputs and error drop before any clock edge
      rst = 1'b1;
      #1;
      check("midwait rst fwd1", {25'd0, o1}, 32'd0);
      check("midwait rst fwd0", {25'd0, o0}, 32'd0);
      check("midwait rst err", {30'd0, err1, err0}, 32'd0);
`ifdef HAZARD_CTRL_PERF_EN
      check("midwait rst cnt", rc1 | bc1 | mc1 | rc0 | bc0 | mc0, 32'd0);
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      clear_model();
      step("post rst fast", mv(0,0,0, 0,0,0, 0,0,0,1,1), NONE, NONE);
      step("post rst done", mv(0,0,0, 0,0,0, 0,0,0,0,0), NONE, NONE);
      check("post rst err", {30'd0, err1, err0}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

`default_nettype wire
